flexbex_ibex_irq_prio_ctrl: RTL and testbench

FLEXBEX_IBEX_IRQ_PRIO_CTRL -- requirements
Module: flexbex_ibex_irq_prio_ctrl

---
 rtl/flexbex_ibex_pkg.sv | 6 +
 rtl/flexbex_ibex_irq_prio_enc.sv | 19 +
 rtl/flexbex_ibex_irq_prio_ctrl.sv | 77 +++++++
 tb/tb_flexbex_ibex_irq_prio_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/flexbex_ibex_pkg.sv
// flexbex_ibex_pkg: shared FSM state type and default sizing for the interrupt controller
package flexbex_ibex_pkg;
  localparam int NUM_IRQ_DEF = 16;
  localparam int ID_W_DEF = 5;
  typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_ACK} irq_state_e;
endpackage

// File: rtl/flexbex_ibex_irq_prio_enc.sv
// flexbex_ibex_irq_prio_enc: combinational fixed-priority encoder, lowest set index wins
module flexbex_ibex_irq_prio_enc
  import flexbex_ibex_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    index_o
);
  // scan from the top down so the lowest requesting index is written last
  always_comb begin
    valid_o = |req_i;
    index_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req_i[i]) index_o = ID_W'(i);
  end
endmodule

// File: rtl/flexbex_ibex_irq_prio_ctrl.sv
// flexbex_ibex_irq_prio_ctrl: edge/level interrupt capture, priority select and ack handshake
module flexbex_ibex_irq_prio_ctrl
  import flexbex_ibex_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               m_IE_i,
  input  logic               ctrl_ack_i,
  input  logic               ctrl_kill_i,
  output logic               irq_req_ctrl_o,
  output logic [ID_W-1:0]    irq_id_ctrl_o,
  output logic [NUM_IRQ-1:0] irq_pending_o,
  output logic               irq_ack_o,
  output logic [ID_W-1:0]    irq_ack_id_o
);
  irq_state_e state_q, state_d;
  logic [ID_W-1:0] id_q, id_d, win_id;
  logic [NUM_IRQ-1:0] irq_q, irq_d, pend_q, pend_d, edge_det, ack_clr, eligible;
  logic win_valid;

  assign irq_d = irq_i;
  assign edge_det = irq_i & ~irq_q;
  assign irq_pending_o = (EDGE_MASK & (pend_q | edge_det)) | (~EDGE_MASK & irq_i);
  assign eligible = irq_pending_o & irq_en_i;
  // a fresh edge in the same cycle as its ack must not be lost, so set beats clear
  assign pend_d = (pend_q & ~ack_clr) | (edge_det & EDGE_MASK);

  flexbex_ibex_irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_enc (
    .req_i   (eligible),
    .valid_o (win_valid),
    .index_o (win_id)
  );

  // handshake FSM: id is frozen once a request is presented until ack or kill
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    ack_clr = '0;
    case (state_q)
      IRQ_IDLE: if (m_IE_i && win_valid) begin
        state_d = IRQ_REQ;
        id_d = win_id;
      end
      IRQ_REQ: if (ctrl_ack_i) begin
        state_d = IRQ_ACK;
        ack_clr = EDGE_MASK & (NUM_IRQ'(1) << id_q);
      end else if (ctrl_kill_i) state_d = IRQ_IDLE;
      default: state_d = IRQ_IDLE;
    endcase
  end

  // state, id, edge history and sticky pending bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IRQ_IDLE;
      id_q <= '0;
      irq_q <= '0;
      pend_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      irq_q <= irq_d;
      pend_q <= pend_d;
    end
  end

  assign irq_req_ctrl_o = state_q == IRQ_REQ;
  assign irq_ack_o = state_q == IRQ_ACK;
  assign irq_id_ctrl_o = id_q;
  assign irq_ack_id_o = irq_ack_o ? id_q : '0;
endmodule

// File: tb/tb_flexbex_ibex_irq_prio_ctrl.sv
// tb_flexbex_ibex_irq_prio_ctrl: directed self-checking bench for the interrupt priority controller
module tb_flexbex_ibex_irq_prio_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] irq_i, irq_en_i, irq_pending_o;
  logic m_IE_i, ctrl_ack_i, ctrl_kill_i;
  logic irq_req_ctrl_o, irq_ack_o;
  logic [4:0] irq_id_ctrl_o, irq_ack_id_o;
  int total = 0;
  int bad = 0;

  flexbex_ibex_irq_prio_ctrl #(.NUM_IRQ(16), .ID_W(5), .EDGE_MASK(16'h0011)) dut (
    .clk            (clk),
    .rst            (rst),
    .irq_i          (irq_i),
    .irq_en_i       (irq_en_i),
    .m_IE_i         (m_IE_i),
    .ctrl_ack_i     (ctrl_ack_i),
    .ctrl_kill_i    (ctrl_kill_i),
    .irq_req_ctrl_o (irq_req_ctrl_o),
    .irq_id_ctrl_o  (irq_id_ctrl_o),
    .irq_pending_o  (irq_pending_o),
    .irq_ack_o      (irq_ack_o),
    .irq_ack_id_o   (irq_ack_id_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [4:0] id);
    chk({tag, "_req"}, 32'(irq_req_ctrl_o), 32'(req));
    if (req) chk({tag, "_id"}, 32'(irq_id_ctrl_o), 32'(id));
  endtask

  task automatic chk_ack(input string tag, input logic ack, input logic [4:0] id);
    chk({tag, "_ack"}, 32'(irq_ack_o), 32'(ack));
    chk({tag, "_ackid"}, 32'(irq_ack_id_o), 32'(id));
  endtask

  initial begin
    rst = 1'b1;
    irq_i = '0;
    irq_en_i = 16'hFFFF;
    m_IE_i = 1'b1;
    ctrl_ack_i = 1'b0;
    ctrl_kill_i = 1'b0;
    tick();
    tick();
    chk_req("rst", 1'b0, 5'd0);
    chk("rst_id", 32'(irq_id_ctrl_o), 32'd0);
    chk_ack("rst", 1'b0, 5'd0);
    chk("rst_pend", 32'(irq_pending_o), 32'd0);
    rst = 1'b0;
    tick();
    // level sources 3 and 5: lowest index wins, re-request after ack
    irq_i = 16'h0028;
    #1;
    chk("lvl_pend", 32'(irq_pending_o), 32'h0028);
    chk_req("lvl_c0", 1'b0, 5'd0);
    tick();
    chk_req("lvl_c1", 1'b1, 5'd3);
    tick();
    chk_req("lvl_c2", 1'b1, 5'd3);
    ctrl_ack_i = 1'b1;
    tick();
    ctrl_ack_i = 1'b0;
    chk_ack("lvl_c3", 1'b1, 5'd3);
    chk_req("lvl_c3", 1'b0, 5'd0);
    tick();
    chk_req("lvl_c4", 1'b0, 5'd0);
    chk_ack("lvl_c4", 1'b0, 5'd0);
    tick();
    chk_req("lvl_c5", 1'b1, 5'd3);
    irq_i = '0;
    ctrl_kill_i = 1'b1;
    tick();
    ctrl_kill_i = 1'b0;
    chk_req("lvl_kill", 1'b0, 5'd0);
    // edge pulse on source 0 while request 5 is held
    irq_i = 16'h0020;
    tick();
    chk_req("edg_r5", 1'b1, 5'd5);
    irq_i = 16'h0021;
    #1;
    chk("edg_pulse_pend0", 32'(irq_pending_o[0]), 32'd1);
    tick();
    irq_i = 16'h0020;
    #1;
    chk("edg_sticky_pend0", 32'(irq_pending_o[0]), 32'd1);
    chk_req("edg_hold5", 1'b1, 5'd5);
    tick();
    chk_req("edg_hold5b", 1'b1, 5'd5);
    irq_i = '0;
    ctrl_ack_i = 1'b1;
    tick();
    ctrl_ack_i = 1'b0;
    chk_ack("edg_ack5", 1'b1, 5'd5);
    tick();
    chk_req("edg_idle", 1'b0, 5'd0);
    tick();
    chk_req("edg_r0", 1'b1, 5'd0);
    ctrl_ack_i = 1'b1;
    tick();
    ctrl_ack_i = 1'b0;
    chk_ack("edg_ack0", 1'b1, 5'd0);
    chk("edg_clr_pend0", 32'(irq_pending_o), 32'd0);
    tick();
    // simultaneous ack and kill: ack wins
    irq_i = 16'h0004;
    tick();
    chk_req("ak_r2", 1'b1, 5'd2);
    ctrl_ack_i = 1'b1;
    ctrl_kill_i = 1'b1;
    tick();
    ctrl_ack_i = 1'b0;
    ctrl_kill_i = 1'b0;
    chk_ack("ak_ack2", 1'b1, 5'd2);
    irq_i = '0;
    tick();
    chk_req("ak_idle", 1'b0, 5'd0);
    // killed edge request keeps its pending bit and is re-requested
    irq_i = 16'h0010;
    tick();
    chk_req("kill_r4", 1'b1, 5'd4);
    ctrl_kill_i = 1'b1;
    tick();
    ctrl_kill_i = 1'b0;
    chk_req("kill_idle", 1'b0, 5'd0);
    chk("kill_pend4", 32'(irq_pending_o[4]), 32'd1);
    tick();
    chk_req("kill_rereq4", 1'b1, 5'd4);
    ctrl_ack_i = 1'b1;
    tick();
    ctrl_ack_i = 1'b0;
    irq_i = '0;
    #1;
    chk_ack("kill_ack4", 1'b1, 5'd4);
    chk("kill_clr_pend", 32'(irq_pending_o), 32'd0);
    tick();
    // global enable gating and per-source masking
    m_IE_i = 1'b0;
    irq_i = 16'hFFFF;
    tick();
    chk_req("mie0_a", 1'b0, 5'd0);
    tick();
    chk_req("mie0_b", 1'b0, 5'd0);
    m_IE_i = 1'b1;
    tick();
    chk_req("mie1_r0", 1'b1, 5'd0);
    ctrl_kill_i = 1'b1;
    irq_en_i = 16'hFFFE;
    tick();
    ctrl_kill_i = 1'b0;
    chk_req("mask_idle", 1'b0, 5'd0);
    tick();
    chk_req("mask_r1", 1'b1, 5'd1);
    m_IE_i = 1'b0;
    tick();
    chk_req("mie_fall_hold1", 1'b1, 5'd1);
    m_IE_i = 1'b1;
    irq_en_i = 16'hFFFF;
    // asynchronous reset in the middle of a request
    #2;
    rst = 1'b1;
    irq_i = 16'h0001;
    #1;
    chk_req("arst_req", 1'b0, 5'd0);
    chk("arst_id", 32'(irq_id_ctrl_o), 32'd0);
    chk_ack("arst", 1'b0, 5'd0);
    tick();
    chk_ack("arst_hold", 1'b0, 5'd0);
    rst = 1'b0;
    #1;
    chk_req("rel_c1", 1'b0, 5'd0);
    chk("rel_pend0", 32'(irq_pending_o[0]), 32'd1);
    tick();
    chk_req("rel_c2", 1'b1, 5'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
